// File: rtl/dram_sched.sv
// Two-requester single-bank DRAM command scheduler with open-row tracking and idle auto-precharge.
// Latency from accept: T_CMD+1 (hit), 2*T_CMD+1 (row closed), 3*T_CMD+1 (row miss); reads extend on late DRAM_valid.
// Backpressure: one request in flight; ready only in IDLE to the round-robin winner whose valid is high.
module dram_sched #(
    parameter int T_CMD      = 5,
    parameter int IDLE_CLOSE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_addr,
    input  logic [3:0]  req0_wen,
    input  logic [31:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_addr,
    input  logic [3:0]  req1_wen,
    input  logic [31:0] req1_wdata,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_rdata,
    output logic        DRAM_CSn,
    output logic        DRAM_RASn,
    output logic        DRAM_CASn,
    output logic [3:0]  DRAM_WEn,
    output logic [10:0] DRAM_A,
    output logic [31:0] DRAM_D,
    input  logic [31:0] DRAM_Q,
    input  logic        DRAM_valid
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PRE  = 3'd1;
    localparam logic [2:0] ACT  = 3'd2;
    localparam logic [2:0] RD   = 3'd3;
    localparam logic [2:0] WR   = 3'd4;

    localparam int CW = $clog2(T_CMD + 1);
    localparam int IW = $clog2(IDLE_CLOSE + 1);
    localparam logic [CW-1:0] PHASE_LAST = CW'(T_CMD - 1);
    // The counter value seen in the last of IDLE_CLOSE idle cycles.
    localparam logic [IW-1:0] CLOSE_AT   = IW'(IDLE_CLOSE - 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idle_cnt;
    logic          row_open;
    logic [10:0]   row_addr;
    logic          last_gnt;
    logic          pend;
    logic          lat_id;
    logic [10:0]   lat_row;
    logic [9:0]    lat_col;
    logic [3:0]    lat_wen;
    logic [31:0]   lat_wdata;
    logic          rd_got;
    logic [31:0]   rd_data;

    logic          gnt_id;
    logic [10:0]   gnt_row;
    logic [9:0]    gnt_col;
    logic [3:0]    gnt_wen;
    logic [31:0]   gnt_wdata;
    logic          accept;
    logic          phase_end;

    // Only row and column bits take part in addressing; byte offset and high bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req0_addr[31:23], req0_addr[1:0], req1_addr[31:23], req1_addr[1:0]};

    assign phase_end = (cnt == PHASE_LAST);

    // Round-robin pick: on conflict the requester not granted last time wins; field mux follows the pick.
    always_comb begin
        gnt_id     = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
        gnt_row    = gnt_id ? req1_addr[22:12] : req0_addr[22:12];
        gnt_col    = gnt_id ? req1_addr[11:2]  : req0_addr[11:2];
        gnt_wen    = gnt_id ? req1_wen         : req0_wen;
        gnt_wdata  = gnt_id ? req1_wdata       : req0_wdata;
        accept     = rst && (state == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && !gnt_id;
        req1_ready = accept && gnt_id;
    end

    // DRAM pins: command on cycle 0 of each phase, NOP afterwards, deselected in IDLE; write data held through WR.
    always_comb begin
        DRAM_CSn  = 1'b1;
        DRAM_RASn = 1'b1;
        DRAM_CASn = 1'b1;
        DRAM_WEn  = 4'hF;
        DRAM_A    = '0;
        DRAM_D    = '0;
        if (state != IDLE) DRAM_CSn = 1'b0;
        if (state == WR)   DRAM_D   = lat_wdata;
        if (cnt == '0) begin
            case (state)
                PRE: begin DRAM_RASn = 1'b0; DRAM_WEn = 4'h0; DRAM_A = row_addr; end
                ACT: begin DRAM_RASn = 1'b0; DRAM_A = lat_row; end
                RD:  begin DRAM_CASn = 1'b0; DRAM_A = {1'b0, lat_col}; end
                WR:  begin DRAM_CASn = 1'b0; DRAM_WEn = lat_wen; DRAM_A = {1'b0, lat_col}; end
                default: ;
            endcase
        end
    end

    // Phase sequencing, open-row tracking, idle auto-close and registered completion pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idle_cnt  <= '0;
            row_open  <= 1'b0;
            row_addr  <= '0;
            last_gnt  <= 1'b0;
            pend      <= 1'b0;
            lat_id    <= 1'b0;
            lat_row   <= '0;
            lat_col   <= '0;
            lat_wen   <= '0;
            lat_wdata <= '0;
            rd_got    <= 1'b0;
            rd_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            idle_cnt  <= '0;
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    rd_got <= 1'b0;
                    if (accept) begin
                        last_gnt  <= gnt_id;
                        lat_id    <= gnt_id;
                        lat_row   <= gnt_row;
                        lat_col   <= gnt_col;
                        lat_wen   <= gnt_wen;
                        lat_wdata <= gnt_wdata;
                        if (row_open && (row_addr == gnt_row)) begin
                            state <= (gnt_wen == 4'hF) ? RD : WR;
                        end else if (row_open) begin
                            state <= PRE;
                            pend  <= 1'b1;
                        end else begin
                            state <= ACT;
                        end
                    end else if (row_open) begin
                        // Auto-close carries no request, so PRE falls back to IDLE afterwards.
                        if (idle_cnt == CLOSE_AT) begin
                            state <= PRE;
                            pend  <= 1'b0;
                        end else begin
                            idle_cnt <= idle_cnt + IW'(1);
                        end
                    end
                end
                PRE: begin
                    row_open <= 1'b0;
                    if (phase_end) begin
                        cnt   <= '0;
                        pend  <= 1'b0;
                        state <= pend ? ACT : IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ACT: begin
                    row_open <= 1'b1;
                    row_addr <= lat_row;
                    if (phase_end) begin
                        cnt   <= '0;
                        state <= (lat_wen == 4'hF) ? RD : WR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RD: begin
                    // Early read data is held so the response still lands at the end of the minimum phase.
                    if (DRAM_valid && !rd_got) begin
                        rd_got  <= 1'b1;
                        rd_data <= DRAM_Q;
                    end
                    if (!phase_end) begin
                        cnt <= cnt + CW'(1);
                    end else if (rd_got || DRAM_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= lat_id;
                        rsp_rdata <= rd_got ? rd_data : DRAM_Q;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                WR: begin
                    if (phase_end) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= lat_id;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_sched.sv
// Directed bench for dram_sched: row hit/miss/empty paths, round-robin, idle auto-close and mid-phase reset.
// A small DRAM model returns read data a programmable number of cycles after each read command.
// Commands and completions are logged with their cycle numbers and compared against hand-derived timing.
module tb_dram_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_addr = '0, req1_addr = '0;
    logic [3:0]  req0_wen = 4'hF, req1_wen = 4'hF;
    logic [31:0] req0_wdata = '0, req1_wdata = '0;
    logic        rsp_valid, rsp_id;
    logic [31:0] rsp_rdata;
    logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
    logic [3:0]  DRAM_WEn;
    logic [10:0] DRAM_A;
    logic [31:0] DRAM_D;
    logic [31:0] DRAM_Q = '0;
    logic        DRAM_valid = 1'b0;

    typedef struct { int cyc; logic ras; logic cas; logic [3:0] we; logic [10:0] a; logic [31:0] d; } cmd_t;
    typedef struct { int cyc; logic id; logic [31:0] rd; } rsp_t;
    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    cmd_t mc;
    rsp_t mr;

    int          n_chk = 0, n_fail = 0, cyc = 0;
    int          rd_dly = 4, rd_left = 0;
    logic [31:0] rd_q = '0;

    dram_sched #(.T_CMD(5), .IDLE_CLOSE(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_wen(req0_wen), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_wen(req1_wen), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn), .DRAM_WEn(DRAM_WEn),
        .DRAM_A(DRAM_A), .DRAM_D(DRAM_D), .DRAM_Q(DRAM_Q), .DRAM_valid(DRAM_valid)
    );

    always #5 clk = ~clk;

    // Cycle number, advanced on every rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // DRAM read model: strobe DRAM_valid rd_dly cycles after a read command; Q is garbage otherwise.
    always @(posedge clk) begin
        #1;
        if (!DRAM_CSn && DRAM_RASn && !DRAM_CASn && DRAM_WEn == 4'hF) begin
            rd_left    = rd_dly;
            DRAM_valid = 1'b0;
            DRAM_Q     = ~rd_q;
        end else if (rd_left > 0) begin
            rd_left    = rd_left - 1;
            DRAM_valid = (rd_left == 0);
            DRAM_Q     = (rd_left == 0) ? rd_q : ~rd_q;
        end else begin
            DRAM_valid = 1'b0;
            DRAM_Q     = ~rd_q;
        end
    end

    // Mid-cycle monitor: log every non-NOP command and every completion pulse.
    always @(negedge clk) begin
        if (!DRAM_CSn && (!DRAM_RASn || !DRAM_CASn)) begin
            mc.cyc = cyc; mc.ras = DRAM_RASn; mc.cas = DRAM_CASn;
            mc.we = DRAM_WEn; mc.a = DRAM_A; mc.d = DRAM_D;
            cmd_q.push_back(mc);
        end
        if (rsp_valid) begin
            mr.cyc = cyc; mr.id = rsp_id; mr.rd = rsp_rdata;
            rsp_q.push_back(mr);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the directed sequence");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cmd(input string tag, input int i, input int ecyc, input logic eras,
                           input logic ecas, input logic [3:0] ewe, input logic [10:0] ea);
        chk({tag, ".present"}, 32'(cmd_q.size() > i), 1);
        if (cmd_q.size() > i) begin
            chk({tag, ".cyc"}, cmd_q[i].cyc, ecyc);
            chk({tag, ".op"}, {cmd_q[i].ras, cmd_q[i].cas, cmd_q[i].we}, {eras, ecas, ewe});
            chk({tag, ".a"}, 32'(cmd_q[i].a), 32'(ea));
        end
    endtask

    task automatic chk_rsp(input string tag, input int i, input int ecyc, input logic eid);
        chk({tag, ".present"}, 32'(rsp_q.size() > i), 1);
        if (rsp_q.size() > i) begin
            chk({tag, ".cyc"}, rsp_q[i].cyc, ecyc);
            chk({tag, ".id"}, 32'(rsp_q[i].id), 32'(eid));
        end
    endtask

    task automatic chk_rd(input string tag, input int i, input logic [31:0] erd);
        if (rsp_q.size() > i) chk(tag, rsp_q[i].rd, erd);
        else chk({tag, ".present"}, 0, 1);
    endtask

    task automatic do_req(input int id, input logic [31:0] addr, input logic [3:0] wen,
                          input logic [31:0] wd, output int acc);
        acc = -1;
        if (id == 0) begin req0_addr = addr; req0_wen = wen; req0_wdata = wd; req0_valid = 1'b1; end
        else         begin req1_addr = addr; req1_wen = wen; req1_wdata = wd; req1_valid = 1'b1; end
        #1;
        for (int k = 0; k < 100; k++) begin
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                acc = cyc;
                break;
            end
            tick();
        end
        chk("accept_wait", 32'(acc >= 0), 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int limit);
        for (int k = 0; k < limit; k++) begin
            if (rsp_q.size() >= n) break;
            tick();
        end
        chk("rsp_wait", 32'(rsp_q.size() >= n), 1);
    endtask

    int acc, r, gid, gcyc, prev, got;

    initial begin
        // Reset: idle pins, cleared response, no ready even with a valid request.
        tick(); tick();
        req0_valid = 1'b1;
        #1;
        chk("rst_ready0", 32'(req0_ready), 0);
        chk("rst_pins", {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn}, 7'h7F);
        chk("rst_a_d", {DRAM_A, DRAM_D}, 0);
        chk("rst_rsp", {rsp_valid, rsp_id, rsp_rdata}, 0);
        req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        cmd_q.delete(); rsp_q.delete();

        // Step 1: read with no row open -> ACT, then read command, data returned with id 0.
        rd_dly = 4; rd_q = 32'hCAFE_0001;
        do_req(0, 32'h0000_1004, 4'hF, 32'h0, acc);
        wait_rsp(1, 60);
        chk_cmd("s1_act", 0, acc + 1, 1'b0, 1'b1, 4'hF, 11'h001);
        chk_cmd("s1_rd", 1, acc + 6, 1'b1, 1'b0, 4'hF, 11'h001);
        chk("s1_ncmd", cmd_q.size(), 2);
        chk_rsp("s1_rsp", 0, acc + 11, 1'b0);
        chk_rd("s1_rdata", 0, 32'hCAFE_0001);
        cmd_q.delete(); rsp_q.delete();

        // Step 2: write hit to the open row, data held through the phase.
        do_req(1, 32'h0000_1008, 4'h0, 32'hDEAD_BEEF, acc);
        tick(); tick();
        chk("s2_d_hold", DRAM_D, 32'hDEAD_BEEF);
        chk("s2_nop", {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn}, 7'h3F);
        wait_rsp(1, 40);
        chk_cmd("s2_wr", 0, acc + 1, 1'b1, 1'b0, 4'h0, 11'h002);
        if (cmd_q.size() > 0) chk("s2_wr.d", cmd_q[0].d, 32'hDEAD_BEEF);
        chk("s2_ncmd", cmd_q.size(), 1);
        chk_rsp("s2_rsp", 0, acc + 6, 1'b1);
        cmd_q.delete(); rsp_q.delete();

        // Step 3: row miss -> PRE, ACT, read; early DRAM_valid still answers at the end of the phase.
        rd_dly = 1; rd_q = 32'h1234_5678;
        do_req(0, 32'h0000_2000, 4'hF, 32'h0, acc);
        wait_rsp(1, 60);
        chk_cmd("s3_pre", 0, acc + 1, 1'b0, 1'b1, 4'h0, 11'h001);
        chk_cmd("s3_act", 1, acc + 6, 1'b0, 1'b1, 4'hF, 11'h002);
        chk_cmd("s3_rd", 2, acc + 11, 1'b1, 1'b0, 4'hF, 11'h000);
        chk_rsp("s3_rsp", 0, acc + 16, 1'b0);
        chk_rd("s3_rdata", 0, 32'h1234_5678);
        cmd_q.delete(); rsp_q.delete();

        // Step 4: both requesters held valid for four grants -> 1,0,1,0, back to back hits.
        rd_dly = 4; rd_q = 32'h4444_0000;
        req0_addr = 32'h0000_2004; req0_wen = 4'hF;
        req1_addr = 32'h0000_2008; req1_wen = 4'hF;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        prev = 0;
        for (int g = 0; g < 4; g++) begin
            got = 0;
            for (int k = 0; k < 40; k++) begin
                if (req0_ready || req1_ready) begin got = 1; break; end
                tick();
            end
            chk("s4_grant_wait", got, 1);
            gid = int'(req1_ready); gcyc = cyc;
            chk("s4_one_ready", 32'(req0_ready & req1_ready), 0);
            chk("s4_grant_id", gid, (g % 2 == 0) ? 1 : 0);
            if (g > 0) chk("s4_grant_gap", gcyc - prev, 6);
            prev = gcyc;
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(4, 40);
        for (int i = 0; i < 4; i++) chk_rsp("s4_rsp", i, prev - 18 + 6 * i + 6, (i % 2 == 0) ? 1'b1 : 1'b0);
        r = (rsp_q.size() >= 4) ? rsp_q[3].cyc : cyc;
        cmd_q.delete(); rsp_q.delete();

        // Step 5: 16 idle cycles close the row; a request arriving during that PRE waits, then ACT only.
        got = 0;
        for (int k = 0; k < 40; k++) begin
            if (cmd_q.size() > 0) begin got = 1; break; end
            tick();
        end
        chk("s5_pre_wait", got, 1);
        chk_cmd("s5_pre", 0, r + 16, 1'b0, 1'b1, 4'h0, 11'h002);
        do_req(1, 32'h0000_3010, 4'hA, 32'h0BAD_F00D, acc);
        chk("s5_acc", acc, r + 21);
        wait_rsp(1, 40);
        chk_cmd("s5_act", 1, r + 22, 1'b0, 1'b1, 4'hF, 11'h003);
        chk_cmd("s5_wr", 2, r + 27, 1'b1, 1'b0, 4'hA, 11'h004);
        if (cmd_q.size() > 2) chk("s5_wr.d", cmd_q[2].d, 32'h0BAD_F00D);
        chk("s5_ncmd", cmd_q.size(), 3);
        chk_rsp("s5_rsp", 0, r + 32, 1'b1);
        cmd_q.delete(); rsp_q.delete();

        // Step 6: reset in the middle of a write -> idle pins, no completion, row closed, pointer favours 1.
        do_req(0, 32'h0000_3020, 4'h0, 32'h55AA_55AA, acc);
        tick();
        rst = 1'b0;
        tick();
        chk("s6_rst_pins", {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn}, 7'h7F);
        chk("s6_rst_a_d", {DRAM_A, DRAM_D}, 0);
        chk("s6_rst_rsp", 32'(rsp_valid), 0);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("s6_cmds_after_rst", cmd_q.size(), 1);
        chk("s6_no_rsp", rsp_q.size(), 0);
        cmd_q.delete(); rsp_q.delete();
        rd_dly = 4; rd_q = 32'h6666_7777;
        req0_addr = 32'h0000_3000; req0_wen = 4'hF;
        req1_addr = 32'h0000_3004; req1_wen = 4'hF;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("s6_rr_after_rst", {req0_ready, req1_ready}, 2'b01);
        req0_valid = 1'b0;
        do_req(1, 32'h0000_3004, 4'hF, 32'h0, acc);
        wait_rsp(1, 60);
        chk_cmd("s6_act", 0, acc + 1, 1'b0, 1'b1, 4'hF, 11'h003);
        chk_cmd("s6_rd", 1, acc + 6, 1'b1, 1'b0, 4'hF, 11'h001);
        chk_rsp("s6_rsp", 0, acc + 11, 1'b1);
        chk_rd("s6_rdata", 0, 32'h6666_7777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
